// File: rtl/flex_counter_staged.sv
// Two-level staged counter: an inner stage counter with runtime length and an outer round counter.
// Define FLEX_CNT_SATURATE_EN to freeze the counters once all rounds complete.
module flex_counter_staged #(
    parameter int NUM_CNT_BITS = 6,
    parameter int NUM_TO_COUNT = 40,
    parameter int NUM_RND_BITS = 4,
    parameter int NUM_ROUNDS   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_RND_BITS-1:0] round_out,
    output logic                    done_flag,
    output logic                    all_done
);

    localparam logic [NUM_CNT_BITS-1:0] DEF_LEN  = NUM_CNT_BITS'(NUM_TO_COUNT);
    localparam logic [NUM_RND_BITS-1:0] LAST_RND = NUM_RND_BITS'(NUM_ROUNDS - 1);
`ifdef FLEX_CNT_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    logic [NUM_CNT_BITS-1:0] eff_len;
    logic [NUM_CNT_BITS-1:0] last_cnt;
    logic                    wrap;
    logic                    halted;

    // A zero runtime length falls back to the build-time default, so eff_len >= 1.
    assign eff_len  = (rollover_val == '0) ? DEF_LEN : rollover_val;
    assign last_cnt = eff_len - NUM_CNT_BITS'(1);
    // >= rather than == so a shortened stage wraps instead of running to overflow.
    assign wrap     = (count_out >= last_cnt);
    assign halted   = SATURATE && all_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out <= '0;
            round_out <= '0;
            done_flag <= 1'b0;
            all_done  <= 1'b0;
        end else if (clear) begin
            count_out <= '0;
            round_out <= '0;
            done_flag <= 1'b0;
            all_done  <= 1'b0;
        end else begin
            done_flag <= 1'b0;
            if (count_enable && !halted) begin
                if (wrap) begin
                    done_flag <= 1'b1;
                    if (round_out == LAST_RND) begin
                        all_done <= 1'b1;
                        if (SATURATE) begin
                            count_out <= last_cnt;
                        end else begin
                            count_out <= '0;
                            round_out <= '0;
                        end
                    end else begin
                        count_out <= '0;
                        round_out <= round_out + NUM_RND_BITS'(1);
                    end
                end else begin
                    count_out <= count_out + NUM_CNT_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_flex_counter_staged.sv
// Scoreboard bench for flex_counter_staged: stimulus pushes expected outputs, a monitor pops and compares.
module tb_flex_counter_staged;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       count_enable = 1'b0;
    logic [5:0] rollover_val = '0;
    logic [5:0] count_out;
    logic [3:0] round_out;
    logic       done_flag;
    logic       all_done;

    typedef struct {
        logic [5:0] cnt;
        logic [3:0] rnd;
        logic       done;
        logic       all;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    event smp_ev;

    flex_counter_staged dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .count_enable (count_enable),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .round_out    (round_out),
        .done_flag    (done_flag),
        .all_done     (all_done)
    );

    always #5 clk = ~clk;

    // Monitor: samples 1 time unit after each rising edge (or an async-check request).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or smp_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (count_out !== e.cnt || round_out !== e.rnd ||
                    done_flag !== e.done || all_done !== e.all) begin
                    errors++;
                    $display("FAIL %s: got cnt=%0d rnd=%0d done=%b all=%b, want cnt=%0d rnd=%0d done=%b all=%b",
                             e.tag, count_out, round_out, done_flag, all_done,
                             e.cnt, e.rnd, e.done, e.all);
                end
            end
        end
    end

    function automatic void push(input int cnt, input int rnd, input bit done,
                                 input bit all, input string tag);
        exp_t e;
        e.cnt = 6'(cnt); e.rnd = 4'(rnd); e.done = done; e.all = all; e.tag = tag;
        exp_q.push_back(e);
    endfunction

    // Drive one edge's inputs at the falling edge and queue the outputs expected after it.
    task automatic step(input bit en, input bit clr, input int rv, input int cnt,
                        input int rnd, input bit done, input bit all, input string tag);
        @(negedge clk);
        count_enable = en;
        clear        = clr;
        rollover_val = 6'(rv);
        push(cnt, rnd, done, all, tag);
    endtask

    initial begin
        // Reset is visible without any clock edge.
        #2;
        push(0, 0, 0, 0, "reset_state");
        ->smp_ev;
        @(negedge clk);
        rst = 1'b0;

        // Default length 40, ten rounds: after n edges cnt=n%40, rnd=(n/40)%10.
        for (int n = 1; n <= 400; n++) begin
`ifdef FLEX_CNT_SATURATE_EN
            if (n == 400) step(1, 0, 0, 39, 9, 1, 1, "run400_final");
            else
`endif
            step(1, 0, 0, n % 40, (n / 40) % 10, (n % 40) == 0, n >= 400,
                 (n % 40 == 0) ? "run_wrap" : "run_count");
        end
        for (int n = 401; n <= 410; n++) begin
`ifdef FLEX_CNT_SATURATE_EN
            step(1, 0, 0, 39, 9, 0, 1, "post_all_saturated");
`else
            step(1, 0, 0, n - 400, 0, 0, 1, "post_all_continue");
`endif
        end
`ifdef FLEX_CNT_SATURATE_EN
        step(0, 0, 0, 39, 9, 0, 1, "enable_low_hold");
`else
        step(0, 0, 0, 10, 0, 0, 1, "enable_low_hold");
`endif
        step(0, 1, 0, 0, 0, 0, 0, "clear_all");

        // R=1: every enabled edge is a wrap.
        for (int k = 1; k <= 5; k++) step(1, 0, 1, 0, k, 1, 0, "r1_wrap");
        step(0, 0, 1, 0, 5, 0, 0, "r1_idle");
        step(0, 1, 0, 0, 0, 0, 0, "clear2");

        // Shrink length below current count mid-stage.
        for (int k = 1; k <= 20; k++) step(1, 0, 0, k, 0, 0, 0, "pre_shrink");
        step(1, 0, 8, 0, 1, 1, 0, "shrink_wrap");
        for (int k = 1; k <= 7; k++) step(1, 0, 8, k, 1, 0, 0, "r8_count");
        step(1, 0, 8, 0, 2, 1, 0, "r8_wrap");

        // Clear coincident with a wrapping edge suppresses the pulse.
        step(0, 1, 0, 0, 0, 0, 0, "clear3");
        step(1, 0, 3, 1, 0, 0, 0, "r3_count1");
        step(1, 0, 3, 2, 0, 0, 0, "r3_count2");
        step(1, 1, 3, 0, 0, 0, 0, "clear_on_wrap");
        step(0, 0, 3, 0, 0, 0, 0, "no_pulse_after_clear");

        // Async reset mid-stage discards progress.
        for (int k = 1; k <= 5; k++) step(1, 0, 0, k, 0, 0, 0, "pre_rst");
        @(negedge clk);
        count_enable = 1'b0;
        #2 rst = 1'b1;
        push(0, 0, 0, 0, "async_rst_mid");
        ->smp_ev;
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 1, 0, 0, 0, "first_after_rst");
        step(0, 0, 0, 1, 0, 0, 0, "hold_after_rst");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
